// File: rtl/tick_to_pulse_pkg.sv
// Shared definitions for the tick-to-pulse generator: state encoding,
// default timing parameters and a small elaboration-time helper.
package tick_to_pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  localparam int DEF_HIGH_CYCLES = 4;
  localparam int DEF_LOW_CYCLES  = 2;
  localparam int DEF_PEND_W      = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_to_pulse_if.sv
// Request/status bundle between a tick source and the pulse generator.
interface tick_to_pulse_if #(
  parameter int PEND_W = tick_to_pulse_pkg::DEF_PEND_W
);
  logic              tick;
  logic              sig;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (output tick, input sig, busy, pending, overflow);
  modport slave  (input tick, output sig, busy, pending, overflow);
endinterface

// File: rtl/sat_updown_counter.sv
// Up/down counter clamped at 0 and 2**W-1; sat_hit is a registered one-cycle
// flag raised when an increment is refused at the top.
module sat_updown_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         sat_hit
);
  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] count_q, count_d;
  logic         hit_q, hit_d;

  always_comb begin
    count_d = count_q;
    hit_d   = 1'b0;
    if (inc && !dec) begin
      if (count_q == MAX) hit_d   = 1'b1;
      else                count_d = count_q + 1'b1;
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      hit_q   <= hit_d;
    end
  end

  assign count   = count_q;
  assign sat_hit = hit_q;
endmodule

// File: rtl/tick_to_pulse.sv
// Converts one-cycle ticks into fixed-width high pulses separated by a
// guaranteed low gap; ticks arriving mid-pulse are queued in a saturating count.
module tick_to_pulse
  import tick_to_pulse_pkg::*;
#(
  parameter int HIGH_CYCLES = DEF_HIGH_CYCLES,
  parameter int LOW_CYCLES  = DEF_LOW_CYCLES,
  parameter int PEND_W      = DEF_PEND_W
) (
  input  logic             clk,
  input  logic             reset_n,
  tick_to_pulse_if.slave   bus
);
  localparam int PH_W = $clog2(max_int(HIGH_CYCLES, LOW_CYCLES) + 1);
  localparam logic [PH_W-1:0] HIGH_LOAD = PH_W'(HIGH_CYCLES - 1);
  localparam logic [PH_W-1:0] LOW_LOAD  = PH_W'(LOW_CYCLES - 1);

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              sig_q, sig_d;
  logic              busy_q, busy_d;
  logic              inc, dec, ovf;
  logic [PEND_W-1:0] pend;
  logic              phase_last, have_req;

  assign phase_last = (phase_q == '0);
  assign have_req   = (pend != '0);

  // phase_q counts down to 0 in each timed state; 0 marks the final cycle.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    inc     = 1'b0;
    dec     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.tick || have_req) begin
          state_d = ST_HIGH;
          phase_d = HIGH_LOAD;
          dec     = !bus.tick;
        end
      end
      ST_HIGH: begin
        inc = bus.tick;
        if (phase_last) begin
          state_d = ST_LOW;
          phase_d = LOW_LOAD;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      ST_LOW: begin
        if (phase_last && (bus.tick || have_req)) begin
          // back-to-back pulse: a same-cycle tick is used in place of a queued one
          state_d = ST_HIGH;
          phase_d = HIGH_LOAD;
          dec     = !bus.tick;
        end else begin
          inc = bus.tick;
          if (phase_last) begin
            state_d = ST_IDLE;
            phase_d = '0;
          end else begin
            phase_d = phase_q - PH_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
    sig_d  = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      sig_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
    end
  end

  sat_updown_counter #(.W(PEND_W)) u_pend (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (inc),
    .dec     (dec),
    .count   (pend),
    .sat_hit (ovf)
  );

  assign bus.sig      = sig_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pend;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_tick_to_pulse.sv
// Bench for tick_to_pulse: directed timing scenarios plus a random run checked
// against a pulse-window reference model and a rising-edge loopback count.
module tb_tick_to_pulse;
  localparam int H    = 4;
  localparam int L    = 2;
  localparam int PW   = 3;
  localparam int MAXP = 7;

  logic clk = 1'b0;
  logic reset_n;

  tick_to_pulse_if #(.PEND_W(PW)) bus();

  tick_to_pulse #(.HIGH_CYCLES(H), .LOW_CYCLES(L), .PEND_W(PW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0, n_bad = 0, cyc = 0;
  int   m_start, m_back;
  bit   m_ovf;
  logic sig_h [256];
  logic busy_h[256];
  logic ovf_h [256];
  int   pend_h[256];
  int   rises, ovf_cnt;
  logic prev_sig;

  typedef struct {
    bit tick;
    bit sig;
    bit busy;
    int pend;
    bit ovf;
  } vec_t;
  vec_t vec[19];

  // Model: a pulse occupies the window [m_start, m_start+H+L-1]; m_back is the backlog.
  function automatic bit in_hi(input int t);
    return (t >= m_start) && (t < m_start + H);
  endfunction

  function automatic bit in_busy(input int t);
    return (t >= m_start) && (t < m_start + H + L);
  endfunction

  task automatic model_step(input int t, input bit tk);
    m_ovf = 1'b0;
    if (!in_busy(t)) begin
      if (tk) m_start = t + 1;
    end else if (t == m_start + H + L - 1) begin
      if (tk) m_start = t + 1;
      else if (m_back > 0) begin
        m_back--;
        m_start = t + 1;
      end
    end else if (tk) begin
      if (m_back < MAXP) m_back++;
      else m_ovf = 1'b1;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input bit tk);
    bus.tick = tk;
    @(posedge clk);
    cyc++;
    model_step(cyc - 1, tk);
    @(negedge clk);
    chk("model_sig",  int'(bus.sig),      int'(in_hi(cyc)));
    chk("model_busy", int'(bus.busy),     int'(in_busy(cyc)));
    chk("model_pend", int'(bus.pending),  m_back);
    chk("model_ovf",  int'(bus.overflow), int'(m_ovf));
    if (cyc < 256) begin
      sig_h[cyc]  = bus.sig;
      busy_h[cyc] = bus.busy;
      ovf_h[cyc]  = bus.overflow;
      pend_h[cyc] = int'(bus.pending);
    end
    if (bus.sig && !prev_sig) rises++;
    prev_sig = bus.sig;
    if (bus.overflow) ovf_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic do_reset();
    bus.tick = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    cyc      = 0;
    m_start  = -1000;
    m_back   = 0;
    m_ovf    = 1'b0;
    rises    = 0;
    ovf_cnt  = 0;
    prev_sig = 1'b0;
    for (int i = 0; i < 256; i++) begin
      sig_h[i] = 1'b0; busy_h[i] = 1'b0; ovf_h[i] = 1'b0; pend_h[i] = 0;
    end
  endtask

  initial begin
    int pend_tab[19];
    int pmax, sent;

    // ticks at cycles 10,11,12; row i = tick in cycle 10+i, outputs at cycle 11+i
    pend_tab = '{0, 1, 2, 2, 2, 2, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 19; i++) begin
      vec[i].tick = (i < 3);
      vec[i].sig  = (i <= 3) || (i >= 6 && i <= 9) || (i >= 12 && i <= 15);
      vec[i].busy = (i < 18);
      vec[i].pend = pend_tab[i];
      vec[i].ovf  = 1'b0;
    end

    reset_n  = 1'b0;
    bus.tick = 1'b0;
    @(negedge clk);
    chk("rst_sig",  int'(bus.sig),      0);
    chk("rst_busy", int'(bus.busy),     0);
    chk("rst_pend", int'(bus.pending),  0);
    chk("rst_ovf",  int'(bus.overflow), 0);

    // single tick
    do_reset();
    idle(10);
    step(1'b1);
    idle(10);
    for (int c = 1; c <= 21; c++) begin
      chk("single_sig",  int'(sig_h[c]),  int'(c >= 11 && c <= 14));
      chk("single_busy", int'(busy_h[c]), int'(c >= 11 && c <= 16));
      chk("single_pend", pend_h[c], 0);
    end

    // three consecutive ticks, table driven
    do_reset();
    idle(10);
    for (int i = 0; i < 19; i++) begin
      step(vec[i].tick);
      chk("tab_sig",  int'(bus.sig),      int'(vec[i].sig));
      chk("tab_busy", int'(bus.busy),     int'(vec[i].busy));
      chk("tab_pend", int'(bus.pending),  vec[i].pend);
      chk("tab_ovf",  int'(bus.overflow), int'(vec[i].ovf));
    end

    // ten ticks in a row: saturation and a single dropped tick
    do_reset();
    idle(10);
    repeat (10) step(1'b1);
    idle(60);
    pmax = 0;
    for (int c = 1; c <= 80; c++) begin
      chk("sat_ovf", int'(ovf_h[c]), int'(c == 20));
      if (pend_h[c] > pmax) pmax = pend_h[c];
    end
    chk("sat_pend_peak", pmax, 7);
    chk("sat_pulses", rises, 9);
    chk("sat_idle_end", int'(busy_h[80]), 0);

    // tick in the final LOW cycle resumes HIGH with no idle gap
    do_reset();
    idle(10);
    step(1'b1);
    idle(5);
    step(1'b1);
    idle(8);
    for (int c = 1; c <= 25; c++)
      chk("b2b_sig", int'(sig_h[c]), int'((c >= 11 && c <= 14) || (c >= 17 && c <= 20)));
    for (int c = 11; c <= 23; c++)
      chk("b2b_busy", int'(busy_h[c]), int'(c <= 22));

    // asynchronous reset mid-pulse with two queued requests
    do_reset();
    idle(10);
    repeat (3) step(1'b1);
    chk("pre_rst_pend", int'(bus.pending), 2);
    chk("pre_rst_sig",  int'(bus.sig),     1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_sig",  int'(bus.sig),     0);
    chk("async_pend", int'(bus.pending), 0);
    chk("async_busy", int'(bus.busy),    0);
    do_reset();
    idle(20);
    chk("post_rst_no_pulse", rises, 0);
    do_reset();
    step(1'b1);
    chk("first_edge_tick", int'(bus.sig), 1);
    idle(8);

    // random ticks with rising-edge loopback count
    do_reset();
    sent = 0;
    while (sent < 1000 && cyc < 20000) begin
      bit tk;
      tk = ($urandom_range(0, 9) < 4);
      step(tk);
      if (tk) sent++;
    end
    chk("rand_sent", sent, 1000);
    for (int i = 0; i < 200; i++) begin
      if (!bus.busy && bus.pending == '0) break;
      step(1'b0);
    end
    chk("rand_drained", int'(bus.busy), 0);
    chk("loopback_count", rises, sent - ovf_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
